// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// State codes, opcode constants, ALU operation and datapath mux selects.
// Also holds the decoded instruction class used inside the controller.
package mips_ctrl_pkg;

   // FSM state codes (also exported on the debug state port)
   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_MEMADDR = 4'd2;
   localparam logic [3:0] ST_MEM_RD  = 4'd3;
   localparam logic [3:0] ST_MEM_WR  = 4'd4;
   localparam logic [3:0] ST_WB_MEM  = 4'd5;
   localparam logic [3:0] ST_EXEC_R  = 4'd6;
   localparam logic [3:0] ST_EXEC_I  = 4'd7;
   localparam logic [3:0] ST_WB_ALU  = 4'd8;
   localparam logic [3:0] ST_BRANCH  = 4'd9;
   localparam logic [3:0] ST_JUMP    = 4'd10;
   localparam logic [3:0] ST_FAULT   = 4'd15;

   // Opcode field values
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   // ALU operation
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   // ALU source B select
   localparam logic [1:0] SRCB_RT      = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Instruction class captured in DECODE
   typedef enum logic [2:0] {
      OT_NONE, OT_R, OT_ADDI, OT_LW, OT_SW, OT_BEQ, OT_BNE, OT_J
   } op_type_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags the last permitted wait.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over tick, count saturates at the limit.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic nrst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [7:0] count_q;

   // Wait-cycle counter: cleared on state entry, advanced on each stalled cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         count_q <= '0;
      else if (clear)
         count_q <= '0;
      else if (tick && !expired)
         count_q <= count_q + 8'd1;
   end

   // A stall in this cycle would be the MEM_TIMEOUT-th one
   assign expired = (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: R/ADDI/SW 4 cycles, LW 5, BEQ/BNE/J 3, plus memory stall cycles.
// Backpressure: stalls in memory states on mem_ready=0; stall timeout -> sticky FAULT.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 15,
   parameter int HAS_BNE     = 1
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg_write,
   output logic                mux_write_rt_rd,
   output logic                mux_reg_src_alu_mem,
   output logic                mux_alu_src_a,
   output logic [1:0]          mux_alu_src_b,
   output logic [1:0]          mux_pc_src,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                instr_done,
   output logic                fault,
   output logic [3:0]          state
);

   logic [3:0] state_q, state_nxt;
   op_type_t   op_dec, op_type_q;
   logic       in_wait, expired;
   logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c, done_c;
   logic [1:0] alu_op_c;

   // Opcode classification; BNE is only legal when the build enables it
   always_comb begin
      op_dec = OT_NONE;
      if      (opcode == OPCODE_W'(OP_R))    op_dec = OT_R;
      else if (opcode == OPCODE_W'(OP_ADDI)) op_dec = OT_ADDI;
      else if (opcode == OPCODE_W'(OP_LW))   op_dec = OT_LW;
      else if (opcode == OPCODE_W'(OP_SW))   op_dec = OT_SW;
      else if (opcode == OPCODE_W'(OP_BEQ))  op_dec = OT_BEQ;
      else if (opcode == OPCODE_W'(OP_BNE) && HAS_BNE != 0) op_dec = OT_BNE;
      else if (opcode == OPCODE_W'(OP_J))    op_dec = OT_J;
   end

   assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .nrst    (nrst),
      .clear   (state_nxt != state_q),
      .tick    (in_wait && !mem_ready),
      .expired (expired)
   );

   // Next-state selection; a ready memory always beats the timeout
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_FETCH:   if (mem_ready) state_nxt = ST_DECODE;
                     else if (expired) state_nxt = ST_FAULT;
         ST_DECODE:  case (op_dec)
                        OT_R:          state_nxt = ST_EXEC_R;
                        OT_ADDI:       state_nxt = ST_EXEC_I;
                        OT_LW, OT_SW:  state_nxt = ST_MEMADDR;
                        OT_BEQ, OT_BNE: state_nxt = ST_BRANCH;
                        OT_J:          state_nxt = ST_JUMP;
                        default:       state_nxt = ST_FAULT;
                     endcase
         ST_MEMADDR: state_nxt = (op_type_q == OT_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:  if (mem_ready) state_nxt = ST_WB_MEM;
                     else if (expired) state_nxt = ST_FAULT;
         ST_MEM_WR:  if (mem_ready) state_nxt = ST_FETCH;
                     else if (expired) state_nxt = ST_FAULT;
         ST_EXEC_R, ST_EXEC_I: state_nxt = ST_WB_ALU;
         ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP: state_nxt = ST_FETCH;
         default:    state_nxt = ST_FAULT;
      endcase
   end

   // State register and instruction class latched while in DECODE
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_FETCH;
         op_type_q <= OT_NONE;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_DECODE)
            op_type_q <= op_dec;
      end
   end

   // Per-state datapath controls and raw enables
   always_comb begin
      mem_req_c           = 1'b0;
      mem_we_c            = 1'b0;
      ir_write_c          = 1'b0;
      pc_write_c          = 1'b0;
      reg_write_c         = 1'b0;
      done_c              = 1'b0;
      mux_write_rt_rd     = 1'b1;
      mux_reg_src_alu_mem = 1'b1;
      mux_alu_src_a       = 1'b0;
      mux_alu_src_b       = SRCB_FOUR;
      mux_pc_src          = PCSRC_ALU;
      alu_op_c            = ALU_ADD;
      case (state_q)
         ST_FETCH: begin
            mem_req_c  = 1'b1;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
         end
         ST_DECODE:  mux_alu_src_b = SRCB_IMM_SH2;
         ST_EXEC_R: begin
            mux_alu_src_a = 1'b1;
            mux_alu_src_b = SRCB_RT;
            alu_op_c      = ALU_FUNCT;
         end
         ST_EXEC_I, ST_MEMADDR: begin
            mux_alu_src_a = 1'b1;
            mux_alu_src_b = SRCB_IMM;
         end
         ST_MEM_RD:  mem_req_c = 1'b1;
         ST_MEM_WR: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            done_c    = mem_ready;
         end
         ST_WB_MEM: begin
            reg_write_c         = 1'b1;
            mux_write_rt_rd     = 1'b0;
            mux_reg_src_alu_mem = 1'b0;
            done_c              = 1'b1;
         end
         ST_WB_ALU: begin
            reg_write_c     = 1'b1;
            mux_write_rt_rd = (op_type_q == OT_R);
            done_c          = 1'b1;
         end
         ST_BRANCH: begin
            mux_alu_src_a = 1'b1;
            mux_alu_src_b = SRCB_RT;
            alu_op_c      = ALU_SUB;
            mux_pc_src    = PCSRC_ALUOUT;
            pc_write_c    = (op_type_q == OT_BNE) ? !zero : zero;
            done_c        = 1'b1;
         end
         ST_JUMP: begin
            mux_pc_src = PCSRC_JUMP;
            pc_write_c = 1'b1;
            done_c     = 1'b1;
         end
         default: ;
      endcase
   end

   // Enables are forced low for the whole time reset is held
   assign mem_req    = mem_req_c   & nrst;
   assign mem_we     = mem_we_c    & nrst;
   assign ir_write   = ir_write_c  & nrst;
   assign pc_write   = pc_write_c  & nrst;
   assign reg_write  = reg_write_c & nrst;
   assign instr_done = done_c      & nrst;
   assign alu_op     = ALUOP_W'(alu_op_c);
   assign fault      = (state_q == ST_FAULT);
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (MEM_TIMEOUT=4), plus a HAS_BNE=0 copy.
// Expected per-cycle output vectors are queued per instruction and popped as it runs.
// Vector layout: {state, req, we, irw, pcw, regw, done, fault, rt_rd, reg_src, src_a, src_b, pc_src, alu_op}.
module tb_multicycle_control;
   import mips_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       nrst, nrst_nb, nb_on;
   logic [5:0] opcode;
   logic       zero, mem_ready;

   logic       mem_req, mem_we, ir_write, pc_write, reg_write, wrr, rsrc, srca, instr_done, fault;
   logic [1:0] srcb, pcsrc, alu_op;
   logic [3:0] state;
   logic       mem_req_n, mem_we_n, ir_write_n, pc_write_n, reg_write_n, wrr_n, rsrc_n, srca_n;
   logic       instr_done_n, fault_n;
   logic [1:0] srcb_n, pcsrc_n, alu_op_n;
   logic [3:0] state_n;

   logic [19:0] obs, obs_nb;
   logic [19:0] exp_q[$];
   logic [19:0] exp_nb_q[$];
   logic        rdy_q[$];
   int          n_vec = 0, n_miss = 0;

   localparam logic [6:0] E_NONE  = 7'b0000000;
   localparam logic [6:0] E_F_W   = 7'b1000000;  // fetch stalled
   localparam logic [6:0] E_F_R   = 7'b1011000;  // fetch completes
   localparam logic [6:0] E_MEM   = 7'b1000000;
   localparam logic [6:0] E_WR_W  = 7'b1100000;
   localparam logic [6:0] E_WR_R  = 7'b1100010;
   localparam logic [6:0] E_WB    = 7'b0000110;
   localparam logic [6:0] E_PCW_D = 7'b0001010;  // pc_write + instr_done
   localparam logic [6:0] E_DONE  = 7'b0000010;
   localparam logic [6:0] E_FAULT = 7'b0000001;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(4), .HAS_BNE(1)) dut (
      .clk(clk), .nrst(nrst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .mux_write_rt_rd(wrr), .mux_reg_src_alu_mem(rsrc),
      .mux_alu_src_a(srca), .mux_alu_src_b(srcb), .mux_pc_src(pcsrc), .alu_op(alu_op),
      .instr_done(instr_done), .fault(fault), .state(state)
   );

   multicycle_control #(.MEM_TIMEOUT(4), .HAS_BNE(0)) dut_nb (
      .clk(clk), .nrst(nrst_nb), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req_n), .mem_we(mem_we_n), .ir_write(ir_write_n), .pc_write(pc_write_n),
      .reg_write(reg_write_n), .mux_write_rt_rd(wrr_n), .mux_reg_src_alu_mem(rsrc_n),
      .mux_alu_src_a(srca_n), .mux_alu_src_b(srcb_n), .mux_pc_src(pcsrc_n), .alu_op(alu_op_n),
      .instr_done(instr_done_n), .fault(fault_n), .state(state_n)
   );

   assign obs    = {state, mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, fault,
                    wrr, rsrc, srca, srcb, pcsrc, alu_op};
   assign obs_nb = {state_n, mem_req_n, mem_we_n, ir_write_n, pc_write_n, reg_write_n,
                    instr_done_n, fault_n, wrr_n, rsrc_n, srca_n, srcb_n, pcsrc_n, alu_op_n};

   task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %05h expected %05h", tag, got, want);
      end
   endtask

   // Expected vector from the state's documented mux settings and the listed enables
   function automatic logic [19:0] ev(input logic [3:0] st, input logic [6:0] en, input logic rt_rd);
      logic       a, rs;
      logic [1:0] b, pc, alu;
      a   = (st == ST_EXEC_R) || (st == ST_EXEC_I) || (st == ST_MEMADDR) || (st == ST_BRANCH);
      rs  = (st != ST_WB_MEM);
      b   = (st == ST_DECODE) ? 2'd3 :
            ((st == ST_EXEC_R) || (st == ST_BRANCH)) ? 2'd0 :
            ((st == ST_EXEC_I) || (st == ST_MEMADDR)) ? 2'd2 : 2'd1;
      pc  = (st == ST_BRANCH) ? 2'd1 : (st == ST_JUMP) ? 2'd2 : 2'd0;
      alu = (st == ST_EXEC_R) ? 2'd2 : (st == ST_BRANCH) ? 2'd1 : 2'd0;
      return {st, en, rt_rd, rs, a, b, pc, alu};
   endfunction

   task automatic p(input logic rdy, input logic [3:0] st, input logic [6:0] en, input logic rt_rd);
      rdy_q.push_back(rdy);
      exp_q.push_back(ev(st, en, rt_rd));
   endtask

   // Entered and left at posedge+1; outputs compared at the falling edge
   task automatic run(input string tag);
      while (exp_q.size() > 0) begin
         mem_ready = rdy_q.pop_front();
         @(negedge clk);
         chk(tag, obs, exp_q.pop_front());
         if (exp_nb_q.size() > 0)
            chk({tag, "_nb"}, obs_nb, exp_nb_q.pop_front());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      nrst_nb = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("reset", obs, ev(ST_FETCH, E_NONE, 1'b1));
      @(posedge clk);
      #1;
      nrst = 1'b1;
      nrst_nb = nb_on;
   endtask

   initial begin
      nrst = 1'b0; nrst_nb = 1'b0; nb_on = 1'b0;
      opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      opcode = OP_R;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1);
      p(1, ST_EXEC_R, E_NONE, 1); p(1, ST_WB_ALU, E_WB, 1);
      run("rtype");

      opcode = OP_ADDI;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1);
      p(1, ST_EXEC_I, E_NONE, 1); p(1, ST_WB_ALU, E_WB, 0);
      run("addi");

      // LW with three stalls, ready on the last allowed wait cycle
      opcode = OP_LW;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_MEMADDR, E_NONE, 1);
      for (int i = 0; i < 3; i++) p(0, ST_MEM_RD, E_MEM, 1);
      p(1, ST_MEM_RD, E_MEM, 1); p(1, ST_WB_MEM, E_WB, 0);
      run("lw_wait");

      opcode = OP_SW;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1);
      p(1, ST_MEMADDR, E_NONE, 1); p(1, ST_MEM_WR, E_WR_R, 1);
      run("sw");

      opcode = OP_BEQ; zero = 1'b1;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_BRANCH, E_PCW_D, 1);
      run("beq_taken");
      zero = 1'b0;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_BRANCH, E_DONE, 1);
      run("beq_not");
      opcode = OP_BNE; zero = 1'b1;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_BRANCH, E_DONE, 1);
      run("bne_not");

      opcode = OP_J;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_JUMP, E_PCW_D, 1);
      run("jump");

      // Fetch stalled three cycles, ready wins on the fourth
      for (int i = 0; i < 3; i++) p(0, ST_FETCH, E_F_W, 1);
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_JUMP, E_PCW_D, 1);
      run("fetch_ready_at_limit");

      // Fetch timeout: four stalled cycles then a sticky fault
      for (int i = 0; i < 4; i++) p(0, ST_FETCH, E_F_W, 1);
      for (int i = 0; i < 20; i++) p(1'(i % 2), ST_FAULT, E_FAULT, 1);
      run("fetch_timeout");
      do_reset();

      opcode = 6'b111111;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1);
      for (int i = 0; i < 3; i++) p(1, ST_FAULT, E_FAULT, 1);
      run("illegal_op");
      do_reset();

      // BNE taken on the main copy, illegal on the HAS_BNE=0 copy
      nb_on = 1'b1;
      do_reset();
      opcode = OP_BNE; zero = 1'b0;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_BRANCH, E_PCW_D, 1);
      exp_nb_q.push_back(ev(ST_FETCH, E_F_R, 1));
      exp_nb_q.push_back(ev(ST_DECODE, E_NONE, 1));
      exp_nb_q.push_back(ev(ST_FAULT, E_FAULT, 1));
      run("bne_taken");
      nb_on = 1'b0;
      do_reset();

      // Reset pulse in the middle of a stalled store
      opcode = OP_SW;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_MEMADDR, E_NONE, 1);
      p(0, ST_MEM_WR, E_WR_W, 1); p(0, ST_MEM_WR, E_WR_W, 1);
      run("sw_stall");
      mem_ready = 1'b0;
      #2;
      chk("sw_before_rst", obs, ev(ST_MEM_WR, E_WR_W, 1));
      nrst = 1'b0;
      #1;
      chk("sw_during_rst", obs, ev(ST_FETCH, E_NONE, 1));
      @(negedge clk);
      nrst = 1'b1;
      #1;
      chk("after_rst_release", obs, ev(ST_FETCH, E_F_W, 1));
      @(posedge clk);
      #1;
      opcode = OP_J;
      p(1, ST_FETCH, E_F_R, 1); p(1, ST_DECODE, E_NONE, 1); p(1, ST_JUMP, E_PCW_D, 1);
      run("restart_jump");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
